control_sequencer: RTL and testbench

- Downstream consumer of the 6-bit one-hot T-state ring counter in the SAP-1 datapath.
- Decodes the current T-state together with the instruction-register opcode into the SAP-1 control word.
- Owns the sticky halt latch, a ring-integrity monitor and a retired-instruction counter.
- Its outputs drive every load/enable pin on the bus: PC, MAR, RAM, IR, A, ALU, B and the output register.

---
 rtl/sap1_pkg.sv | 41 ++++
 rtl/control_matrix.sv | 61 ++++++
 rtl/control_sequencer.sv | 85 ++++++++
 tb/tb_control_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sap1_pkg.sv
// Shared SAP-1 control definitions: opcodes, control-word layout, NOP word and T-state indices.
package sap1_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_LDA = 4'b0000;
    localparam opcode_t OP_ADD = 4'b0001;
    localparam opcode_t OP_SUB = 4'b0010;
    localparam opcode_t OP_OUT = 4'b1110;
    localparam opcode_t OP_HLT = 4'b1111;

    // Field order matches the bus pin order of ctrl_word, MSB first.
    typedef struct packed {
        logic cp;
        logic ep;
        logic lm_;
        logic ce_;
        logic li_;
        logic ei_;
        logic la_;
        logic ea;
        logic su;
        logic eu;
        logic lb_;
        logic lo_;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_NOP = 12'b0011_1110_0011;

    localparam int T1 = 0;
    localparam int T2 = 1;
    localparam int T3 = 2;
    localparam int T4 = 3;
    localparam int T5 = 4;
    localparam int T6 = 5;

    function automatic logic is_defined_op(input opcode_t op);
        return op inside {OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT};
    endfunction

endpackage

// File: rtl/control_matrix.sv
// Combinational SAP-1 microcode matrix: one-hot T-state plus opcode to raw control word.
module control_matrix
    import sap1_pkg::*;
#(
    parameter int T_STATES     = 6,
    parameter int OPCODE_WIDTH = 4
) (
    input  logic [T_STATES-1:0]     t_state,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output ctrl_word_t              raw_word
);

    always_comb begin
        // NOTE: every path starts from the NOP default so no field can hold its old value (no latch).
        raw_word = CTRL_NOP;
        if (t_state[T1]) begin
            raw_word.ep  = 1'b1;
            raw_word.lm_ = 1'b0;
        end else if (t_state[T2]) begin
            raw_word.cp = 1'b1;
        end else if (t_state[T3]) begin
            raw_word.ce_ = 1'b0;
            raw_word.li_ = 1'b0;
        end else if (t_state[T4]) begin
            case (opcode)
                OP_LDA, OP_ADD, OP_SUB: begin
                    raw_word.lm_ = 1'b0;
                    raw_word.ei_ = 1'b0;
                end
                OP_OUT: begin
                    raw_word.ea  = 1'b1;
                    raw_word.lo_ = 1'b0;
                end
                default: ;
            endcase
        end else if (t_state[T5]) begin
            case (opcode)
                OP_LDA: begin
                    raw_word.ce_ = 1'b0;
                    raw_word.la_ = 1'b0;
                end
                OP_ADD, OP_SUB: begin
                    raw_word.ce_ = 1'b0;
                    raw_word.lb_ = 1'b0;
                    raw_word.su  = (opcode == OP_SUB);
                end
                default: ;
            endcase
        end else if (t_state[T6]) begin
            case (opcode)
                OP_ADD, OP_SUB: begin
                    raw_word.eu  = 1'b1;
                    raw_word.la_ = 1'b0;
                    raw_word.su  = (opcode == OP_SUB);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// SAP-1 control sequencer: microcode decode with halt latch, ring monitor and retired-instruction counter.
// Optional trap on undefined opcodes is compiled in with ILLEGAL_OPCODE_TRAP_EN.
module control_sequencer
    import sap1_pkg::*;
#(
    parameter int T_STATES     = 6,
    parameter int OPCODE_WIDTH = 4,
    parameter int ICOUNT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    clr_,
    input  logic [T_STATES-1:0]     t_state,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output logic [11:0]             ctrl_word,
    output logic                    hlt_,
    output logic                    halted,
    output logic                    ring_err,
    output logic                    illegal_op,
    output logic [ICOUNT_WIDTH-1:0] instr_count
);

    localparam logic [T_STATES-1:0] T4_HOT = T_STATES'(1) << T4;
    localparam logic [T_STATES-1:0] T6_HOT = T_STATES'(1) << T6;

    ctrl_word_t raw_word;
    logic       ring_ok;
    logic       t4_exact;
    logic       t6_exact;
    logic       hlt_req;

    control_matrix #(
        .T_STATES     (T_STATES),
        .OPCODE_WIDTH (OPCODE_WIDTH)
    ) u_matrix (
        .t_state  (t_state),
        .opcode   (opcode),
        .raw_word (raw_word)
    );

    assign ring_ok  = $onehot(t_state);
    assign t4_exact = (t_state == T4_HOT);
    assign t6_exact = (t_state == T6_HOT);

`ifdef ILLEGAL_OPCODE_TRAP_EN
    logic trap_req;

    assign trap_req = t4_exact && !is_defined_op(opcode);
    assign hlt_req  = t4_exact && ((opcode == OP_HLT) || trap_req);

    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            illegal_op <= 1'b0;
        end else if (trap_req) begin
            illegal_op <= 1'b1;
        end
    end
`else
    assign hlt_req    = t4_exact && (opcode == OP_HLT);
    assign illegal_op = 1'b0;
`endif

    // A corrupted ring must never reach the bus, so it outranks the halt and the decode.
    assign hlt_      = ~(halted | hlt_req);
    assign ctrl_word = (halted || !ring_ok) ? CTRL_NOP : raw_word;

    always_ff @(posedge clk or negedge clr_) begin
        // NOTE: only flops are reset and only with <=; the reset is asynchronous so clr_ clears mid-instruction.
        if (!clr_) begin
            halted      <= 1'b0;
            ring_err    <= 1'b0;
            instr_count <= '0;
        end else begin
            if (hlt_req) begin
                halted <= 1'b1;
            end
            if (!ring_ok) begin
                ring_err <= 1'b1;
            end
            if (t6_exact && !halted) begin
                instr_count <= instr_count + ICOUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed plan plus randomized T-state/opcode traffic against a table model.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr_;
    logic [5:0]  t_state;
    logic [3:0]  opcode;
    logic [11:0] ctrl_word;
    logic        hlt_;
    logic        halted;
    logic        ring_err;
    logic        illegal_op;
    logic [7:0]  instr_count;

    int total = 0;
    int bad   = 0;

    bit m_halted   = 1'b0;
    bit m_ring_err = 1'b0;
    bit m_illegal  = 1'b0;
    int m_count    = 0;

`ifdef ILLEGAL_OPCODE_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    localparam logic [11:0] NOP_WORD = 12'b0011_1110_0011;
    localparam int B_CP = 11, B_EP = 10, B_LM = 9, B_CE = 8, B_LI = 7, B_EI = 6;
    localparam int B_LA = 5, B_EA = 4, B_SU = 3, B_EU = 2, B_LB = 1, B_LO = 0;

    control_sequencer dut (
        .clk         (clk),
        .clr_        (clr_),
        .t_state     (t_state),
        .opcode      (opcode),
        .ctrl_word   (ctrl_word),
        .hlt_        (hlt_),
        .halted      (halted),
        .ring_err    (ring_err),
        .illegal_op  (illegal_op),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Index of the single hot bit, or -1 when the ring word is not one-hot.
    function automatic int hot_index(input logic [5:0] ts);
        int n = 0;
        int idx = -1;
        for (int i = 0; i < 6; i++) begin
            if (ts[i]) begin
                n++;
                idx = i;
            end
        end
        return (n == 1) ? idx : -1;
    endfunction

    function automatic bit op_known(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h2, 4'hE, 4'hF};
    endfunction

    // Set of signals asserted in a T-state; asserting a signal flips its NOP level.
    function automatic logic [11:0] active_mask(input int t, input logic [3:0] op);
        logic [11:0] m = '0;
        case (t)
            0: begin m[B_EP] = 1'b1; m[B_LM] = 1'b1; end
            1: m[B_CP] = 1'b1;
            2: begin m[B_CE] = 1'b1; m[B_LI] = 1'b1; end
            3: begin
                if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin
                    m[B_LM] = 1'b1; m[B_EI] = 1'b1;
                end else if (op == 4'hE) begin
                    m[B_EA] = 1'b1; m[B_LO] = 1'b1;
                end
            end
            4: begin
                if (op == 4'h0) begin
                    m[B_CE] = 1'b1; m[B_LA] = 1'b1;
                end else if (op == 4'h1 || op == 4'h2) begin
                    m[B_CE] = 1'b1; m[B_LB] = 1'b1; m[B_SU] = (op == 4'h2);
                end
            end
            5: begin
                if (op == 4'h1 || op == 4'h2) begin
                    m[B_EU] = 1'b1; m[B_LA] = 1'b1; m[B_SU] = (op == 4'h2);
                end
            end
            default: ;
        endcase
        return m;
    endfunction

    task automatic model_reset();
        m_halted   = 1'b0;
        m_ring_err = 1'b0;
        m_illegal  = 1'b0;
        m_count    = 0;
    endtask

    // One clock cycle: drive, optionally pulse clr_, check mid-cycle, then advance the model over the edge.
    task automatic cycle(input logic [5:0] ts, input logic [3:0] op, input bit pulse_clr);
        int          idx;
        bit          halt_now;
        logic [11:0] exp_word;
        t_state = ts;
        opcode  = op;
        if (pulse_clr) begin
            #1 clr_ = 1'b0;
            #1;
            check("clr_halted", halted, 0);
            check("clr_count", instr_count, 0);
            check("clr_ring_err", ring_err, 0);
            check("clr_illegal", illegal_op, 0);
            model_reset();
            clr_ = 1'b1;
            #2;
        end else begin
            #4;
        end
        idx      = hot_index(ts);
        halt_now = (idx == 3) && (op == 4'hF || (TRAP && !op_known(op)));
        exp_word = (idx < 0 || m_halted) ? NOP_WORD : (NOP_WORD ^ active_mask(idx, op));
        check("ctrl_word", ctrl_word, exp_word);
        check("hlt_", hlt_, !(m_halted || halt_now));
        check("halted", halted, m_halted);
        check("ring_err", ring_err, m_ring_err);
        check("illegal_op", illegal_op, m_illegal);
        check("instr_count", instr_count, m_count);
        @(posedge clk);
        #1;
        if (idx < 0) m_ring_err = 1'b1;
        if (idx == 5 && !m_halted) m_count = (m_count + 1) % 256;
        if (halt_now) begin
            m_halted = 1'b1;
            if (TRAP && !op_known(op)) m_illegal = 1'b1;
        end
    endtask

    task automatic instr(input logic [3:0] op, input bit clr_at_t1);
        for (int i = 0; i < 6; i++) begin
            cycle(6'(1 << i), op, clr_at_t1 && (i == 0));
        end
    endtask

    initial begin
        int          pos;
        logic [5:0]  ts;
        logic [3:0]  op;
        bit          pulse;

        clr_    = 1'b0;
        t_state = '0;
        opcode  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_halted", halted, 0);
        check("rst_ring_err", ring_err, 0);
        check("rst_illegal", illegal_op, 0);
        check("rst_count", instr_count, 0);
        check("rst_ctrl_nop", ctrl_word, NOP_WORD);
        check("rst_hlt_", hlt_, 1);
        clr_ = 1'b1;

        // LDA walk, then SUB.
        instr(4'h0, 1'b0);
        check("lda_count", instr_count, 1);
        instr(4'h2, 1'b0);
        check("sub_count", instr_count, 2);

        // HLT: halt, freeze, then asynchronous clear in the middle of T2.
        for (int i = 0; i < 4; i++) cycle(6'(1 << i), 4'hF, 1'b0);
        check("hlt_set", halted, 1);
        cycle(6'b010000, 4'hF, 1'b0);
        cycle(6'b100000, 4'hF, 1'b0);
        instr(4'h1, 1'b0);
        check("hlt_frozen", instr_count, 2);
        cycle(6'b000001, 4'h0, 1'b0);
        cycle(6'b000010, 4'h0, 1'b1);
        check("hlt_cleared", halted, 0);
        for (int i = 2; i < 6; i++) cycle(6'(1 << i), 4'h0, 1'b0);

        // Corrupted ring words.
        cycle(6'b000110, 4'h0, 1'b0);
        check("ring_set", ring_err, 1);
        cycle(6'b000000, 4'h0, 1'b0);
        instr(4'h1, 1'b0);
        check("ring_no_halt", halted, 0);

        // 256 OUT instructions from a fresh count: wraps 255 -> 0.
        for (int j = 0; j < 256; j++) begin
            instr(4'hE, j == 0);
            if (j == 254) check("out_255", instr_count, 255);
        end
        check("out_wrap", instr_count, 0);

        // Undefined opcode.
        instr(4'h5, 1'b0);
`ifdef ILLEGAL_OPCODE_TRAP_EN
        check("trap_illegal", illegal_op, 1);
        check("trap_halted", halted, 1);
        check("trap_count", instr_count, 0);
`else
        check("undef_illegal", illegal_op, 0);
        check("undef_count", instr_count, 1);
`endif

        // Randomized traffic with occasional ring corruption and clears.
        pos = 0;
        op  = 4'(($urandom_range(0, 15)));
        for (int n = 0; n < 600; n++) begin
            if (pos == 0) op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) ts = 6'($urandom_range(0, 63));
            else ts = 6'(1 << pos);
            pulse = (m_halted && $urandom_range(0, 5) == 0) || ($urandom_range(0, 99) == 0);
            cycle(ts, op, pulse);
            pos = (pos + 1) % 6;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
